// File: rtl/pipeline_pkg.sv
// Shared definitions for the MIPS pipeline sequencer: FSM state encodings and
// the default HALT drain length.
package pipeline_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_STEP_WAIT = 3'd2,
    ST_STEP_EXEC = 3'd3,
    ST_DRAIN     = 3'd4,
    ST_HALTED    = 3'd5
  } state_t;

  localparam int DRAIN_DEFAULT = 3;

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard priority: taken branch > load-use stall > jump.
// Produces raw requests; the sequencer gates them with the global enable.
module hazard_detect
  import pipeline_pkg::*;
#(
  parameter int RNBITS = 5
) (
  input  logic              idex_memread,
  input  logic [RNBITS-1:0] idex_rt,
  input  logic [RNBITS-1:0] ifid_rs,
  input  logic [RNBITS-1:0] ifid_rt,
  input  logic              jump,
  input  logic              branch_taken,
  output logic              stall_req,
  output logic              ifid_flush_req,
  output logic              idex_flush_req,
  output logic              exmem_flush_req
);

  logic load_use_s;

  // Register 0 is hardwired, so a load into it never creates a dependency
  assign load_use_s = idex_memread && (idex_rt != {RNBITS{1'b0}}) &&
                      ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

  // Resolve the three hazard sources into stall/flush requests by priority
  always_comb begin
    stall_req       = load_use_s & ~branch_taken;
    ifid_flush_req  = branch_taken | (jump & ~load_use_s);
    idex_flush_req  = branch_taken | load_use_s;
    exmem_flush_req = 1'b0;
  end

endmodule

// File: rtl/pipeline_control.sv
// Central five-stage pipeline sequencer: run/step/drain/halt FSM, gated
// stall and flush strobes, and an enabled-cycle counter.
module pipeline_control
  import pipeline_pkg::*;
#(
  parameter int NBITS  = 32,
  parameter int RNBITS = 5,
  parameter int DRAIN  = DRAIN_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_Start,
  input  logic              i_StepMode,
  input  logic              i_Step,
  input  logic              i_IDEX_MemRead,
  input  logic [RNBITS-1:0] i_IDEX_Rt,
  input  logic [RNBITS-1:0] i_IFID_Rs,
  input  logic [RNBITS-1:0] i_IFID_Rt,
  input  logic              i_Jump,
  input  logic              i_BranchTaken,
  input  logic              i_IDEX_HALT,
  output logic              o_Enable,
  output logic              o_PCWrite,
  output logic              o_IFID_Write,
  output logic              o_IFID_Flush,
  output logic              o_IDEX_Flush,
  output logic              o_EXMEM_Flush,
  output logic              o_Halted,
  output logic [2:0]        o_State,
  output logic [NBITS-1:0]  o_Cycles
);

  localparam int DCW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

  state_t           state_r, state_n_s;
  logic             step_mode_r;
  logic             drain_tick_r;
  logic [DCW-1:0]   drain_cnt_r;
  logic [NBITS-1:0] cycles_r;

  logic enable_s, drain_s, halted_s;
  logic stall_req_s, ifid_flush_req_s, idex_flush_req_s, exmem_flush_req_s;

  hazard_detect #(.RNBITS(RNBITS)) u_hazard (
    .idex_memread    (i_IDEX_MemRead),
    .idex_rt         (i_IDEX_Rt),
    .ifid_rs         (i_IFID_Rs),
    .ifid_rt         (i_IFID_Rt),
    .jump            (i_Jump),
    .branch_taken    (i_BranchTaken),
    .stall_req       (stall_req_s),
    .ifid_flush_req  (ifid_flush_req_s),
    .idex_flush_req  (idex_flush_req_s),
    .exmem_flush_req (exmem_flush_req_s)
  );

  // State register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state_r <= ST_IDLE;
    else          state_r <= state_n_s;
  end

  // Next-state logic
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      ST_IDLE:      if (i_Start) state_n_s = i_StepMode ? ST_STEP_WAIT : ST_RUN;
                    else         state_n_s = ST_IDLE;
      ST_RUN:       if (i_IDEX_HALT) state_n_s = ST_DRAIN;
                    else             state_n_s = ST_RUN;
      ST_STEP_WAIT: if (i_Step) state_n_s = ST_STEP_EXEC;
                    else        state_n_s = ST_STEP_WAIT;
      ST_STEP_EXEC: if (i_IDEX_HALT) state_n_s = ST_DRAIN;
                    else             state_n_s = ST_STEP_WAIT;
      ST_DRAIN:     if (enable_s && (drain_cnt_r == DCW'(DRAIN - 1))) state_n_s = ST_HALTED;
                    else                                              state_n_s = ST_DRAIN;
      ST_HALTED:    state_n_s = ST_HALTED;
      default:      state_n_s = ST_IDLE;
    endcase
  end

  // Output logic: enable per state, then hazard requests gated by enable
  always_comb begin
    enable_s = 1'b0;
    drain_s  = 1'b0;
    halted_s = 1'b0;
    case (state_r)
      ST_IDLE:      enable_s = 1'b0;
      ST_RUN:       enable_s = 1'b1;
      ST_STEP_WAIT: enable_s = 1'b0;
      ST_STEP_EXEC: enable_s = 1'b1;
      ST_DRAIN: begin
        // In step mode each drain cycle is released by an i_Step pulse
        enable_s = ~step_mode_r | drain_tick_r;
        drain_s  = 1'b1;
      end
      ST_HALTED:    halted_s = 1'b1;
      default:      enable_s = 1'b0;
    endcase

    if (drain_s) begin
      o_PCWrite     = 1'b0;
      o_IFID_Write  = 1'b0;
      o_IFID_Flush  = enable_s;
      o_IDEX_Flush  = 1'b0;
      o_EXMEM_Flush = 1'b0;
    end else begin
      o_PCWrite     = enable_s & ~stall_req_s;
      o_IFID_Write  = enable_s & ~stall_req_s;
      o_IFID_Flush  = enable_s & ifid_flush_req_s;
      o_IDEX_Flush  = enable_s & idex_flush_req_s;
      o_EXMEM_Flush = enable_s & exmem_flush_req_s;
    end
  end

  // Mode latch, drain counter, step-drain release and enabled-cycle counter
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      step_mode_r  <= 1'b0;
      drain_tick_r <= 1'b0;
      drain_cnt_r  <= {DCW{1'b0}};
      cycles_r     <= {NBITS{1'b0}};
    end else begin
      if ((state_r == ST_IDLE) && i_Start) step_mode_r <= i_StepMode;
      else                                 step_mode_r <= step_mode_r;
      drain_tick_r <= (state_r == ST_DRAIN) && step_mode_r && i_Step && !drain_tick_r;
      if (state_r != ST_DRAIN) drain_cnt_r <= {DCW{1'b0}};
      else if (enable_s)       drain_cnt_r <= drain_cnt_r + DCW'(1);
      else                     drain_cnt_r <= drain_cnt_r;
      if (enable_s) cycles_r <= cycles_r + NBITS'(1);
      else          cycles_r <= cycles_r;
    end
  end

  assign o_Enable = enable_s;
  assign o_Halted = halted_s;
  assign o_State  = state_r;
  assign o_Cycles = cycles_r;

endmodule

// File: tb/tb_pipeline_control.sv
// Directed bench for pipeline_control: hazard vector table in RUN plus
// hand-written start, halt-drain, reset-in-drain and step-mode sequences.
module tb_pipeline_control;

  logic        i_clk = 1'b0;
  logic        i_reset, i_Start, i_StepMode, i_Step;
  logic        i_IDEX_MemRead, i_Jump, i_BranchTaken, i_IDEX_HALT;
  logic [4:0]  i_IDEX_Rt, i_IFID_Rs, i_IFID_Rt;
  logic        o_Enable, o_PCWrite, o_IFID_Write, o_IFID_Flush, o_IDEX_Flush, o_EXMEM_Flush, o_Halted;
  logic [2:0]  o_State;
  logic [31:0] o_Cycles;

  int total = 0;
  int bad   = 0;

  pipeline_control dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_Start(i_Start), .i_StepMode(i_StepMode),
    .i_Step(i_Step), .i_IDEX_MemRead(i_IDEX_MemRead), .i_IDEX_Rt(i_IDEX_Rt),
    .i_IFID_Rs(i_IFID_Rs), .i_IFID_Rt(i_IFID_Rt), .i_Jump(i_Jump),
    .i_BranchTaken(i_BranchTaken), .i_IDEX_HALT(i_IDEX_HALT),
    .o_Enable(o_Enable), .o_PCWrite(o_PCWrite), .o_IFID_Write(o_IFID_Write),
    .o_IFID_Flush(o_IFID_Flush), .o_IDEX_Flush(o_IDEX_Flush), .o_EXMEM_Flush(o_EXMEM_Flush),
    .o_Halted(o_Halted), .o_State(o_State), .o_Cycles(o_Cycles)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       memread;
    logic [4:0] idex_rt, ifid_rs, ifid_rt;
    logic       jump, branch;
    logic [4:0] exp;  // {PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush}
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic clear_inputs();
    i_Start = 1'b0; i_StepMode = 1'b0; i_Step = 1'b0; i_IDEX_MemRead = 1'b0;
    i_IDEX_Rt = 5'd0; i_IFID_Rs = 5'd0; i_IFID_Rt = 5'd0;
    i_Jump = 1'b0; i_BranchTaken = 1'b0; i_IDEX_HALT = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_enable"}, {31'd0, o_Enable}, 32'd0);
    check({tag, "_wr"}, {30'd0, o_PCWrite, o_IFID_Write}, 32'd0);
    check({tag, "_flush"}, {29'd0, o_IFID_Flush, o_IDEX_Flush, o_EXMEM_Flush}, 32'd0);
    check({tag, "_halted"}, {31'd0, o_Halted}, 32'd0);
    check({tag, "_state"}, {29'd0, o_State}, 32'd0);
    check({tag, "_cycles"}, o_Cycles, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 5'b11000};
    vecs[1]  = '{1'b1, 5'd5,  5'd5,  5'd0,  1'b0, 1'b0, 5'b00010};
    vecs[2]  = '{1'b1, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 5'b11000};
    vecs[3]  = '{1'b1, 5'd5,  5'd3,  5'd5,  1'b0, 1'b0, 5'b00010};
    vecs[4]  = '{1'b1, 5'd5,  5'd3,  5'd4,  1'b0, 1'b0, 5'b11000};
    vecs[5]  = '{1'b0, 5'd5,  5'd5,  5'd5,  1'b0, 1'b0, 5'b11000};
    vecs[6]  = '{1'b1, 5'd5,  5'd5,  5'd0,  1'b0, 1'b1, 5'b11110};
    vecs[7]  = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 5'b11100};
    vecs[8]  = '{1'b1, 5'd7,  5'd1,  5'd7,  1'b1, 1'b0, 5'b00010};
    vecs[9]  = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 5'b11110};
    vecs[10] = '{1'b1, 5'd31, 5'd31, 5'd31, 1'b0, 1'b0, 5'b00010};

    clear_inputs();
    i_reset = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge i_clk);
    i_reset = 1'b1;
    tick();
    check("idle_hold", {29'd0, o_State}, 32'd0);

    // Continuous run: start seen in IDLE, enable from the cycle after the edge
    i_Start = 1'b1;
    #1;
    check("start_cycle_enable", {31'd0, o_Enable}, 32'd0);
    tick();
    i_Start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("run_enable_%0d", i), {31'd0, o_Enable}, 32'd1);
      tick();
    end
    check("cycles_after_10", o_Cycles, 32'd10);

    for (int i = 0; i < 11; i++) begin
      i_IDEX_MemRead = vecs[i].memread; i_IDEX_Rt = vecs[i].idex_rt;
      i_IFID_Rs = vecs[i].ifid_rs; i_IFID_Rt = vecs[i].ifid_rt;
      i_Jump = vecs[i].jump; i_BranchTaken = vecs[i].branch;
      #1;
      check($sformatf("vec_%0d", i),
            {27'd0, o_PCWrite, o_IFID_Write, o_IFID_Flush, o_IDEX_Flush, o_EXMEM_Flush},
            {27'd0, vecs[i].exp});
      tick();
    end
    clear_inputs();
    check("cycles_after_vecs", o_Cycles, 32'd21);

    // HALT in RUN: three drain cycles with fetch frozen, then halted
    i_IDEX_HALT = 1'b1;
    tick();
    i_IDEX_HALT = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("drain_state_%0d", i), {29'd0, o_State}, 32'd4);
      check($sformatf("drain_outs_%0d", i),
            {28'd0, o_Enable, o_PCWrite, o_IFID_Write, o_IFID_Flush}, {28'd0, 4'b1001});
      tick();
    end
    check("halted_flag", {30'd0, o_Halted, o_Enable}, {30'd0, 2'b10});
    check("halted_state", {29'd0, o_State}, 32'd5);
    check("halted_cycles", o_Cycles, 32'd25);
    i_Start = 1'b1;
    tick(); tick();
    i_Start = 1'b0;
    check("halted_ignores_start", {29'd0, o_State}, 32'd5);
    check("halted_cycles_frozen", o_Cycles, 32'd25);

    // Reset asserted mid-drain takes effect without a clock edge
    i_reset = 1'b0;
    #1;
    @(negedge i_clk);
    i_reset = 1'b1;
    i_Start = 1'b1;
    tick();
    i_Start = 1'b0;
    i_IDEX_HALT = 1'b1;
    tick();
    i_IDEX_HALT = 1'b0;
    check("pre_reset_drain", {29'd0, o_State}, 32'd4);
    i_reset = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(negedge i_clk);
    i_reset = 1'b1;

    // Step mode: three spaced pulses give three enabled cycles
    i_Start = 1'b1; i_StepMode = 1'b1;
    tick();
    i_Start = 1'b0; i_StepMode = 1'b0;
    check("step_wait_state", {29'd0, o_State}, 32'd2);
    for (int p = 0; p < 3; p++) begin
      i_Step = 1'b1;
      #1;
      check($sformatf("step_wait_en_%0d", p), {31'd0, o_Enable}, 32'd0);
      tick();
      i_Step = 1'b0;
      check($sformatf("step_exec_%0d", p), {28'd0, o_State, o_Enable}, {28'd0, 3'd3, 1'b1});
      for (int k = 0; k < 3; k++) tick();
      check($sformatf("step_gap_en_%0d", p), {31'd0, o_Enable}, 32'd0);
    end
    check("step_cycles_3", o_Cycles, 32'd3);

    // Step held high: only one enabled cycle per STEP_WAIT visit
    i_Step = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    i_Step = 1'b0;
    check("step_held_cycles", o_Cycles, 32'd5);

    // HALT during a step, then drain released one pulse at a time
    i_Step = 1'b1;
    tick();
    i_Step = 1'b0;
    i_IDEX_HALT = 1'b1;
    tick();
    i_IDEX_HALT = 1'b0;
    check("step_drain_idle", {27'd0, o_State, o_Enable, o_IFID_Flush}, {27'd0, 3'd4, 2'b00});
    for (int p = 0; p < 3; p++) begin
      i_Step = 1'b1;
      tick();
      i_Step = 1'b0;
      check($sformatf("step_drain_en_%0d", p), {28'd0, o_Enable, o_IFID_Flush, o_PCWrite, o_IFID_Write},
            {28'd0, 4'b1100});
      tick();
    end
    check("step_halted", {29'd0, o_State}, 32'd5);
    check("step_halted_cycles", o_Cycles, 32'd9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
